// File: rtl/lsu_stage_pkg.sv
// Shared definitions for the load/store stage: FSM state encoding and
// the func3 size/sign codes for loads and stores.
package lsu_stage_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_WAIT = 2'd2,
    ST_DONE = 2'd3
  } lsu_state_e;

  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;
  localparam logic [2:0] F3_SB  = 3'b000;
  localparam logic [2:0] F3_SH  = 3'b001;
  localparam logic [2:0] F3_SW  = 3'b010;

endpackage

// File: rtl/lsu_stage_if.sv
// Data-memory request/response bus between the load/store stage (master)
// and the memory side (slave). The response channel has no backpressure.
interface lsu_stage_if #(
  parameter int XLEN = 32
);
  logic            mem_req_valid;
  logic            mem_req_ready;
  logic [XLEN-1:0] mem_req_addr;
  logic            mem_req_wen;
  logic [XLEN-1:0] mem_req_wdata;
  logic [3:0]      mem_req_wstrb;
  logic            mem_resp_valid;
  logic [XLEN-1:0] mem_resp_rdata;
  logic            mem_resp_err;

  modport master (
    output mem_req_valid, mem_req_addr, mem_req_wen, mem_req_wdata, mem_req_wstrb,
    input  mem_req_ready, mem_resp_valid, mem_resp_rdata, mem_resp_err
  );

  modport slave (
    input  mem_req_valid, mem_req_addr, mem_req_wen, mem_req_wdata, mem_req_wstrb,
    output mem_req_ready, mem_resp_valid, mem_resp_rdata, mem_resp_err
  );
endinterface

// File: rtl/lsu_align.sv
// Combinational lane alignment: shifts store data/strobe onto byte lanes and
// extracts/extends load data from a word-aligned read.
module lsu_align
  import lsu_stage_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic [1:0]      i_off,
  input  logic [XLEN-1:0] i_wdata,
  input  logic [3:0]      i_wmask,
  input  logic [XLEN-1:0] i_rdata,
  input  logic [2:0]      i_func3,
  output logic [XLEN-1:0] o_wdata,
  output logic [3:0]      o_wstrb,
  output logic [XLEN-1:0] o_rdata
);

  logic [XLEN-1:0] w_sh;

  // Lanes pushed past the top of the word are dropped; misalignment is not trapped.
  assign o_wstrb = i_wmask << i_off;
  assign o_wdata = i_wdata << {i_off, 3'b000};
  assign w_sh    = i_rdata >> {i_off, 3'b000};

  always_comb begin
    o_rdata = '0;
    case (i_func3)
      F3_LB:   o_rdata = {{(XLEN-8){w_sh[7]}}, w_sh[7:0]};
      F3_LH:   o_rdata = {{(XLEN-16){w_sh[15]}}, w_sh[15:0]};
      F3_LW:   o_rdata = w_sh;
      F3_LBU:  o_rdata = {{(XLEN-8){1'b0}}, w_sh[7:0]};
      F3_LHU:  o_rdata = {{(XLEN-16){1'b0}}, w_sh[15:0]};
      default: o_rdata = '0;
    endcase
  end

endmodule

// File: rtl/lsu_stage.sv
// Load/store pipeline stage: one bus transaction per instruction, then a
// single write-back bundle handed downstream under valid/ready.
//
// state | meaning
// IDLE  | empty, accepting a new bundle from execute
// REQ   | memory request presented, waiting for mem_req_ready
// WAIT  | request accepted, waiting for response (or timeout)
// DONE  | write-back bundle valid, waiting for out_ready
module lsu_stage
  import lsu_stage_pkg::*;
#(
  parameter int XLEN         = 32,
  parameter int RESP_TIMEOUT = 0
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            in_valid,
  output logic            in_ready,
  output logic            out_valid,
  input  logic            out_ready,
  output logic            processing,
  input  logic [XLEN-1:0] pc_i,
  input  logic [XLEN-1:0] inst_i,
  input  logic [XLEN-1:0] alu_out_i,
  input  logic [XLEN-1:0] mem_wdata_i,
  input  logic [3:0]      mem_wmask_i,
  input  logic [2:0]      func3_i,
  input  logic            MemRead_i,
  input  logic            MemWrite_i,
  input  logic            RegWrite_i,
  input  logic            zicsr_i,
  input  logic            ebreak_i,
  input  logic [4:0]      wb_addr_i,
  input  logic [XLEN-1:0] csr_rdata_i,
  lsu_stage_if.master     bus,
  output logic [XLEN-1:0] pc_o,
  output logic [XLEN-1:0] inst_o,
  output logic [XLEN-1:0] wb_data_o,
  output logic            RegWrite_o,
  output logic [4:0]      wb_addr_o,
  output logic            ebreak_o,
  output logic            mem_err_o
);

  localparam int CNT_W = (RESP_TIMEOUT > 1) ? $clog2(RESP_TIMEOUT) : 1;
  localparam logic [CNT_W-1:0] CNT_LOAD = (RESP_TIMEOUT > 0) ? CNT_W'(RESP_TIMEOUT - 1) : '0;

  lsu_state_e r_state, w_next;

  logic [XLEN-1:0]  r_pc, r_inst, r_addr, r_wdata, r_wb_data;
  logic [3:0]       r_wmask;
  logic [2:0]       r_func3;
  logic             r_wen, r_regwrite, r_ebreak, r_mem_err;
  logic [4:0]       r_wb_addr;
  logic [CNT_W-1:0] r_cnt;

  logic            w_accept, w_resp, w_timeout, w_req_valid;
  logic [XLEN-1:0] w_wdata_sh, w_load;
  logic [3:0]      w_wstrb_sh;

  assign w_accept  = in_valid & in_ready;
  assign w_resp    = (r_state == ST_WAIT) & bus.mem_resp_valid;
  // Down-counter loaded on request handshake; reaching zero in WAIT ends the wait.
  assign w_timeout = (RESP_TIMEOUT > 0) && (r_state == ST_WAIT) && !bus.mem_resp_valid
                     && (r_cnt == '0);

  always_ff @(posedge clk) begin
    if (rst) r_state <= ST_IDLE;
    else     r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      ST_IDLE: if (w_accept) w_next = (MemRead_i | MemWrite_i) ? ST_REQ : ST_DONE;
      ST_REQ:  if (bus.mem_req_ready) w_next = ST_WAIT;
      ST_WAIT: if (w_resp || w_timeout) w_next = ST_DONE;
      ST_DONE: if (out_ready) w_next = ST_IDLE;
      default: w_next = ST_IDLE;
    endcase
  end

  always_comb begin
    in_ready    = !rst && (r_state == ST_IDLE);
    out_valid   = (r_state == ST_DONE);
    w_req_valid = (r_state == ST_REQ);
    processing  = !rst && ((r_state != ST_IDLE) || in_valid);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_pc       <= '0;
      r_inst     <= '0;
      r_addr     <= '0;
      r_wdata    <= '0;
      r_wmask    <= '0;
      r_func3    <= '0;
      r_wen      <= 1'b0;
      r_regwrite <= 1'b0;
      r_ebreak   <= 1'b0;
      r_wb_addr  <= '0;
      r_wb_data  <= '0;
      r_mem_err  <= 1'b0;
      r_cnt      <= '0;
    end else begin
      if (w_accept) begin
        r_pc       <= pc_i;
        r_inst     <= inst_i;
        r_addr     <= alu_out_i;
        r_wdata    <= mem_wdata_i;
        r_wmask    <= mem_wmask_i;
        r_func3    <= func3_i;
        r_wen      <= MemWrite_i;
        r_regwrite <= RegWrite_i;
        r_ebreak   <= ebreak_i;
        r_wb_addr  <= wb_addr_i;
        r_wb_data  <= zicsr_i ? csr_rdata_i : alu_out_i;
        r_mem_err  <= 1'b0;
      end
      if (r_state == ST_REQ && bus.mem_req_ready) r_cnt <= CNT_LOAD;
      else if (r_state == ST_WAIT && r_cnt != '0) r_cnt <= r_cnt - 1'b1;
      if (w_resp) begin
        r_wb_data <= r_wen ? '0 : w_load;
        r_mem_err <= bus.mem_resp_err;
      end else if (w_timeout) begin
        r_wb_data <= '0;
        r_mem_err <= 1'b1;
      end
    end
  end

  lsu_align #(.XLEN(XLEN)) u_align (
    .i_off   (r_addr[1:0]),
    .i_wdata (r_wdata),
    .i_wmask (r_wmask),
    .i_rdata (bus.mem_resp_rdata),
    .i_func3 (r_func3),
    .o_wdata (w_wdata_sh),
    .o_wstrb (w_wstrb_sh),
    .o_rdata (w_load)
  );

  assign bus.mem_req_valid = w_req_valid;
  assign bus.mem_req_addr  = r_addr;
  assign bus.mem_req_wen   = r_wen;
  assign bus.mem_req_wdata = w_wdata_sh;
  assign bus.mem_req_wstrb = r_wen ? w_wstrb_sh : 4'b0000;

  assign pc_o       = r_pc;
  assign inst_o     = r_inst;
  assign wb_data_o  = r_wb_data;
  assign RegWrite_o = r_regwrite & ~r_mem_err;
  assign wb_addr_o  = r_wb_addr;
  assign ebreak_o   = r_ebreak;
  assign mem_err_o  = r_mem_err;

endmodule

// File: tb/tb_lsu_stage.sv
// Self-checking bench for lsu_stage: directed cases plus randomized
// transactions checked against a byte-level reference model.
module tb_lsu_stage;
  import lsu_stage_pkg::*;

  localparam int XLEN = 32;
  localparam int TO   = 8;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic            in_valid, in_ready, out_valid, out_ready, processing;
  logic [XLEN-1:0] pc_i, inst_i, alu_out_i, mem_wdata_i, csr_rdata_i;
  logic [3:0]      mem_wmask_i;
  logic [2:0]      func3_i;
  logic            MemRead_i, MemWrite_i, RegWrite_i, zicsr_i, ebreak_i;
  logic [4:0]      wb_addr_i;
  logic [XLEN-1:0] pc_o, inst_o, wb_data_o;
  logic            RegWrite_o, ebreak_o, mem_err_o;
  logic [4:0]      wb_addr_o;

  lsu_stage_if #(.XLEN(XLEN)) bus ();

  lsu_stage #(.XLEN(XLEN), .RESP_TIMEOUT(TO)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready),
    .out_valid(out_valid), .out_ready(out_ready), .processing(processing),
    .pc_i(pc_i), .inst_i(inst_i), .alu_out_i(alu_out_i),
    .mem_wdata_i(mem_wdata_i), .mem_wmask_i(mem_wmask_i), .func3_i(func3_i),
    .MemRead_i(MemRead_i), .MemWrite_i(MemWrite_i), .RegWrite_i(RegWrite_i),
    .zicsr_i(zicsr_i), .ebreak_i(ebreak_i), .wb_addr_i(wb_addr_i),
    .csr_rdata_i(csr_rdata_i), .bus(bus),
    .pc_o(pc_o), .inst_o(inst_o), .wb_data_o(wb_data_o),
    .RegWrite_o(RegWrite_o), .wb_addr_o(wb_addr_o),
    .ebreak_o(ebreak_o), .mem_err_o(mem_err_o)
  );

  typedef struct {
    logic [31:0] pc, inst, alu, wdata, csr, rdata;
    logic [3:0]  mask;
    logic [2:0]  f3;
    logic        rd, wr, rw, zicsr, ebreak, err;
    logic [4:0]  wa;
    int          req_dly, resp_dly, out_dly;  // resp_dly 0 = never respond
  } txn_t;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] m_load(input logic [31:0] rdata, input logic [1:0] off,
                                         input logic [2:0] f3);
    logic [7:0]  b[4];
    logic [31:0] v;
    logic [15:0] h;
    int o;
    o = int'(off);
    for (int i = 0; i < 4; i++) b[i] = rdata[8*i +: 8];
    h = '0;
    for (int k = 0; k < 2; k++) if (o + k < 4) h[8*k +: 8] = b[o + k];
    v = '0;
    case (f3)
      3'b000: v = {{24{b[o][7]}}, b[o]};
      3'b100: v = {24'h0, b[o]};
      3'b001: v = {{16{h[15]}}, h};
      3'b101: v = {16'h0, h};
      3'b010: for (int i = 0; i + o < 4; i++) v[8*i +: 8] = b[i + o];
      default: v = '0;
    endcase
    return v;
  endfunction

  function automatic logic [3:0] m_strb(input logic [3:0] mask, input logic [1:0] off);
    logic [3:0] s;
    s = '0;
    for (int i = 0; i < 4; i++) if (i >= int'(off)) s[i] = mask[i - int'(off)];
    return s;
  endfunction

  function automatic logic [31:0] m_wdata(input logic [31:0] wd, input logic [1:0] off);
    logic [31:0] d;
    d = '0;
    for (int i = 0; i < 4; i++)
      if (i >= int'(off)) d[8*i +: 8] = wd[8*(i - int'(off)) +: 8];
    return d;
  endfunction

  function automatic txn_t mk_txn();
    txn_t t;
    t.pc = $urandom; t.inst = $urandom; t.alu = $urandom; t.wdata = $urandom;
    t.csr = $urandom; t.rdata = $urandom; t.mask = 4'b1111; t.f3 = F3_LW;
    t.rd = 1'b0; t.wr = 1'b0; t.rw = 1'b1; t.zicsr = 1'b0; t.ebreak = 1'($urandom_range(0, 1));
    t.err = 1'b0; t.wa = 5'($urandom);
    t.req_dly = 0; t.resp_dly = 1; t.out_dly = 0;
    return t;
  endfunction

  task automatic scramble_inputs();
    pc_i = $urandom; inst_i = $urandom; alu_out_i = $urandom; mem_wdata_i = $urandom;
    csr_rdata_i = $urandom; mem_wmask_i = 4'($urandom); func3_i = 3'($urandom);
    MemRead_i = 1'($urandom); MemWrite_i = 1'($urandom); RegWrite_i = 1'($urandom);
    zicsr_i = 1'($urandom); ebreak_i = 1'($urandom); wb_addr_i = 5'($urandom);
  endtask

  task automatic drive_txn(input txn_t t);
    pc_i = t.pc; inst_i = t.inst; alu_out_i = t.alu; mem_wdata_i = t.wdata;
    csr_rdata_i = t.csr; mem_wmask_i = t.mask; func3_i = t.f3;
    MemRead_i = t.rd; MemWrite_i = t.wr; RegWrite_i = t.rw;
    zicsr_i = t.zicsr; ebreak_i = t.ebreak; wb_addr_i = t.wa;
    in_valid = 1'b1;
  endtask

  // Entered and left at posedge+1 of an IDLE cycle.
  task automatic run_txn(input txn_t t);
    logic        mem, tmo, e_err, e_rw;
    logic [31:0] e_wb;
    int          n;
    mem   = t.rd | t.wr;
    tmo   = mem && (t.resp_dly == 0);
    e_err = mem && (tmo || t.err);
    if (!mem)     e_wb = t.zicsr ? t.csr : t.alu;
    else if (tmo) e_wb = '0;
    else if (t.wr) e_wb = '0;
    else          e_wb = m_load(t.rdata, t.alu[1:0], t.f3);
    e_rw = t.rw & ~e_err;

    drive_txn(t);
    bus.mem_resp_valid = 1'b0;
    @(negedge clk);
    check("in_ready_idle", in_ready, 1);
    check("processing_accept", processing, 1);
    tick();
    in_valid = 1'b0;
    scramble_inputs();

    if (mem) begin
      for (int i = 0; i <= t.req_dly; i++) begin
        bus.mem_req_ready  = (i == t.req_dly);
        bus.mem_resp_valid = 1'($urandom_range(0, 1));
        bus.mem_resp_rdata = $urandom;
        bus.mem_resp_err   = 1'($urandom);
        @(negedge clk);
        check("req_valid", bus.mem_req_valid, 1);
        check("req_addr", bus.mem_req_addr, t.alu);
        check("req_wen", bus.mem_req_wen, t.wr);
        check("req_wstrb", bus.mem_req_wstrb, t.wr ? m_strb(t.mask, t.alu[1:0]) : 4'b0000);
        if (t.wr) check("req_wdata", bus.mem_req_wdata, m_wdata(t.wdata, t.alu[1:0]));
        check("in_ready_req", in_ready, 0);
        check("processing_req", processing, 1);
        check("out_valid_req", out_valid, 0);
        tick();
      end
      bus.mem_req_ready  = 1'b0;
      bus.mem_resp_valid = 1'b0;
      if (tmo) begin
        n = 0;
        while (n < 3 * TO) begin
          @(negedge clk);
          if (out_valid === 1'b1) break;
          n++;
          tick();
        end
        check("timeout_wait_cycles", n, TO);
        tick();
      end else begin
        for (int i = 1; i < t.resp_dly; i++) begin
          @(negedge clk);
          check("req_valid_wait", bus.mem_req_valid, 0);
          check("out_valid_wait", out_valid, 0);
          tick();
        end
        bus.mem_resp_valid = 1'b1;
        bus.mem_resp_rdata = t.rdata;
        bus.mem_resp_err   = t.err;
        @(negedge clk);
        check("out_valid_resp", out_valid, 0);
        tick();
        bus.mem_resp_valid = 1'b0;
      end
    end

    for (int i = 0; i <= t.out_dly; i++) begin
      out_ready          = (i == t.out_dly);
      bus.mem_resp_valid = 1'($urandom_range(0, 1));
      bus.mem_resp_rdata = $urandom;
      bus.mem_resp_err   = 1'($urandom);
      @(negedge clk);
      check("out_valid", out_valid, 1);
      check("wb_data", wb_data_o, e_wb);
      check("regwrite", RegWrite_o, e_rw);
      check("mem_err", mem_err_o, e_err);
      check("pc", pc_o, t.pc);
      check("inst", inst_o, t.inst);
      check("wb_addr", wb_addr_o, t.wa);
      check("ebreak", ebreak_o, t.ebreak);
      check("in_ready_done", in_ready, 0);
      check("processing_done", processing, 1);
      check("req_valid_done", bus.mem_req_valid, 0);
      tick();
    end
    out_ready          = 1'b0;
    bus.mem_resp_valid = 1'b0;
    @(negedge clk);
    check("out_valid_after", out_valid, 0);
    check("in_ready_after", in_ready, 1);
    check("processing_after", processing, 0);
    tick();
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    txn_t t;
    int   kind;
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
    scramble_inputs();
    bus.mem_req_ready = 1'b0; bus.mem_resp_valid = 1'b0;
    bus.mem_resp_rdata = '0; bus.mem_resp_err = 1'b0;
    repeat (3) tick();
    rst = 1'b0;
    @(negedge clk);
    check("rst_out_valid", out_valid, 0);
    check("rst_req_valid", bus.mem_req_valid, 0);
    check("rst_processing", processing, 0);
    check("rst_wb_data", wb_data_o, 0);
    check("rst_pc", pc_o, 0);
    check("rst_regwrite", RegWrite_o, 0);
    check("rst_in_ready", in_ready, 1);
    tick();

    // ALU passthrough
    t = mk_txn(); t.alu = 32'h0000_0123; t.rw = 1'b1;
    run_txn(t);
    // CSR write-back
    t = mk_txn(); t.zicsr = 1'b1; t.out_dly = 1;
    run_txn(t);
    // lb / lbu at a byte-3 address
    t = mk_txn(); t.rd = 1'b1; t.alu = 32'h8000_0003; t.rdata = 32'h80FF_1234; t.f3 = F3_LB;
    t.resp_dly = 2;
    run_txn(t);
    t.f3 = F3_LBU;
    run_txn(t);
    // sh at offset 2 with request backpressure for 5 cycles
    t = mk_txn(); t.wr = 1'b1; t.rw = 1'b0; t.alu = 32'h8000_0002; t.wdata = 32'h0000_ABCD;
    t.mask = 4'b0011; t.f3 = F3_SH; t.req_dly = 5;
    run_txn(t);
    // lw with downstream backpressure for 3 cycles
    t = mk_txn(); t.rd = 1'b1; t.alu = 32'h0000_1000; t.f3 = F3_LW; t.out_dly = 3;
    run_txn(t);
    // lw with bus error
    t = mk_txn(); t.rd = 1'b1; t.alu = 32'h0000_2004; t.f3 = F3_LW; t.err = 1'b1;
    run_txn(t);
    // no response -> timeout error completion
    t = mk_txn(); t.rd = 1'b1; t.alu = 32'h0000_3000; t.f3 = F3_LW; t.resp_dly = 0;
    run_txn(t);

    // reset while in WAIT, then a stray response
    t = mk_txn(); t.rd = 1'b1; t.alu = 32'h0000_4000;
    drive_txn(t);
    tick();
    in_valid = 1'b0;
    bus.mem_req_ready = 1'b1;
    tick();
    bus.mem_req_ready = 1'b0;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    @(negedge clk);
    check("midrst_out_valid", out_valid, 0);
    check("midrst_req_valid", bus.mem_req_valid, 0);
    check("midrst_processing", processing, 0);
    check("midrst_wb_data", wb_data_o, 0);
    check("midrst_pc", pc_o, 0);
    check("midrst_mem_err", mem_err_o, 0);
    check("midrst_req_addr", bus.mem_req_addr, 0);
    tick();
    bus.mem_resp_valid = 1'b1; bus.mem_resp_rdata = 32'hDEAD_BEEF; bus.mem_resp_err = 1'b1;
    tick();
    bus.mem_resp_valid = 1'b0;
    @(negedge clk);
    check("stray_out_valid", out_valid, 0);
    check("stray_processing", processing, 0);
    check("stray_in_ready", in_ready, 1);
    tick();

    for (int n = 0; n < 80; n++) begin
      t = mk_txn();
      t.req_dly  = $urandom_range(0, 3);
      t.resp_dly = ($urandom_range(0, 15) == 0) ? 0 : $urandom_range(1, 5);
      t.out_dly  = $urandom_range(0, 2);
      t.err      = ($urandom_range(0, 7) == 0);
      t.rw       = 1'($urandom);
      kind = $urandom_range(0, 4);
      case (kind)
        0: ;
        1: t.zicsr = 1'b1;
        2: begin
          t.rd = 1'b1;
          case ($urandom_range(0, 4))
            0: t.f3 = F3_LB;
            1: t.f3 = F3_LH;
            2: t.f3 = F3_LW;
            3: t.f3 = F3_LBU;
            default: t.f3 = F3_LHU;
          endcase
        end
        3: begin
          t.wr = 1'b1;
          case ($urandom_range(0, 2))
            0: begin t.f3 = F3_SB; t.mask = 4'b0001; end
            1: begin t.f3 = F3_SH; t.mask = 4'b0011; end
            default: begin t.f3 = F3_SW; t.mask = 4'b1111; end
          endcase
        end
        default: begin
          t.rd = 1'b1;
          t.f3 = 3'($urandom);
        end
      endcase
      run_txn(t);
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
